// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: decode <-> branch controller request/result bundle
// Signals (direction seen from the controller / slave side):
//   in : br_valid, funct3, rd1, rd2, pc, imm, kill
//   out: br_ready, stall, pc_sel, pc_target, flush, br_done, br_taken, br_err
interface branch_ctrl_if #(parameter int XLEN = 32);
    logic            br_valid;
    logic            br_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            kill;
    logic            stall;
    logic            pc_sel;
    logic [XLEN-1:0] pc_target;
    logic            flush;
    logic            br_done;
    logic            br_taken;
    logic            br_err;
    modport master (
        output br_valid, funct3, rd1, rd2, pc, imm, kill,
        input  br_ready, stall, pc_sel, pc_target, flush, br_done, br_taken, br_err
    );
    modport slave (
        input  br_valid, funct3, rd1, rd2, pc, imm, kill,
        output br_ready, stall, pc_sel, pc_target, flush, br_done, br_taken, br_err
    );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves one conditional branch at a time, redirects fetch and flushes the front end
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   bus            slave branch_ctrl_if (request in, redirect/flush/result out)
//   o_cnt_branches out  resolved-branch counter (only with BRANCH_STATS_EN)
//   o_cnt_taken    out  taken-branch counter (only with BRANCH_STATS_EN)
// Optional feature macro: BRANCH_STATS_EN
module branch_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
`ifdef BRANCH_STATS_EN
    branch_ctrl_if.slave bus,
    output logic [31:0] o_cnt_branches,
    output logic [31:0] o_cnt_taken
`else
    branch_ctrl_if.slave bus
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_CMP, S_REDIR, S_FLUSH, S_DONE} state_t;
    // REDIR is the first flush cycle, so FLUSH itself runs FLUSH_CYCLES-1..0
    localparam logic [3:0] CNT_INIT = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);
    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_rd1;
    logic [XLEN-1:0] r_rd2;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_target;
    logic [2:0]      r_f3;
    logic [3:0]      r_cnt;
    logic            r_taken;
    logic            r_err;
    logic [XLEN-1:0] w_target;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic            w_cond;
    logic            w_illegal;
    logic            w_redir;
    always_comb begin
        w_target  = r_pc + r_imm;
        w_eq      = r_rd1 == r_rd2;
        w_lt      = $signed(r_rd1) < $signed(r_rd2);
        w_ltu     = r_rd1 < r_rd2;
        w_cond    = (r_f3 == 3'b000) ? w_eq  :
                    (r_f3 == 3'b001) ? !w_eq :
                    (r_f3 == 3'b100) ? w_lt  :
                    (r_f3 == 3'b101) ? !w_lt :
                    (r_f3 == 3'b110) ? w_ltu :
                    (r_f3 == 3'b111) ? !w_ltu : 1'b0;
        w_illegal = r_f3[2:1] == 2'b01;
        // no compressed instructions, so a target off a 4-byte boundary cannot be fetched
        w_redir   = w_cond && (w_target[1:0] == 2'b00);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.br_valid ? S_CMP : S_IDLE;
            S_CMP:   w_next = w_redir ? S_REDIR : S_DONE;
            S_REDIR: w_next = (FLUSH_CYCLES == 0) ? S_DONE : S_FLUSH;
            S_FLUSH: w_next = (r_cnt == 4'd0) ? S_DONE : S_FLUSH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.kill) w_next = S_IDLE;
        bus.br_ready  = r_state == S_IDLE;
        bus.stall     = (r_state == S_CMP) || (r_state == S_REDIR) || (r_state == S_FLUSH);
        bus.pc_sel    = r_state == S_REDIR;
        bus.flush     = (r_state == S_REDIR) || (r_state == S_FLUSH);
        bus.br_done   = r_state == S_DONE;
        bus.br_taken  = (r_state == S_DONE) && r_taken;
        bus.br_err    = (r_state == S_DONE) && r_err;
        bus.pc_target = r_target;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_pc     <= '0;
            r_imm    <= '0;
            r_f3     <= '0;
            r_target <= '0;
            r_cnt    <= '0;
            r_taken  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && bus.br_valid && !bus.kill) begin
                r_rd1 <= bus.rd1;
                r_rd2 <= bus.rd2;
                r_pc  <= bus.pc;
                r_imm <= bus.imm;
                r_f3  <= bus.funct3;
            end
            if (r_state == S_CMP) begin
                r_target <= w_target;
                r_taken  <= w_redir;
                r_err    <= w_illegal || (w_cond && (w_target[1:0] != 2'b00));
                r_cnt    <= CNT_INIT;
            end
            if (r_state == S_FLUSH) r_cnt <= r_cnt - 4'd1;
        end
    end
`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cnt_branches <= '0;
            o_cnt_taken    <= '0;
        end else if (r_state == S_DONE) begin
            o_cnt_branches <= o_cnt_branches + 32'd1;
            if (r_taken) o_cnt_taken <= o_cnt_taken + 32'd1;
        end
    end
`else
`endif
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: scoreboard bench for branch_ctrl with directed branch vectors
module tb_branch_ctrl;
    typedef struct {
        logic        taken;
        logic        err;
        logic [31:0] target;
        int          lat;
        int          nfl;
        int          nst;
        int          npc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc = 0;
    int   nfl = 0;
    int   nst = 0;
    int   npc = 0;
    logic trk = 1'b0;
    exp_t sb[$];
    branch_ctrl_if #(.XLEN(32)) bus ();
`ifdef BRANCH_STATS_EN
    logic [31:0] cnt_b;
    logic [31:0] cnt_t;
    branch_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .o_cnt_branches(cnt_b), .o_cnt_taken(cnt_t));
`else
    branch_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic exp_t mk(input logic tk, input logic er, input logic [31:0] tg);
        exp_t e;
        e.taken  = tk;
        e.err    = er;
        e.target = tg;
        e.lat    = tk ? 5 : 2;
        e.nfl    = tk ? 3 : 0;
        e.nst    = tk ? 4 : 1;
        e.npc    = tk ? 1 : 0;
        return e;
    endfunction
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) trk = 1'b0;
        else begin
            if (trk) begin
                if (bus.flush) nfl++;
                if (bus.stall) nst++;
            end
            if (bus.pc_sel) begin
                npc++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pc_sel: got unexpected pulse, required none");
                end else chk("pc_target", bus.pc_target, sb[0].target);
            end
            if (bus.br_done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL br_done: got unexpected pulse, required none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("br_taken", 32'(bus.br_taken), 32'(e.taken));
                    chk("br_err", 32'(bus.br_err), 32'(e.err));
                    chk("latency", 32'(cyc - acc), 32'(e.lat));
                    chk("pc_sel_count", 32'(npc), 32'(e.npc));
                    chk("flush_cycles", 32'(nfl), 32'(e.nfl));
                    chk("stall_cycles", 32'(nst), 32'(e.nst));
                end
                trk = 1'b0;
            end
            if (bus.kill) trk = 1'b0;
            if (bus.br_valid && bus.br_ready && !bus.kill) begin
                trk = 1'b1;
                acc = cyc;
                nfl = 0;
                nst = 0;
                npc = 0;
            end
        end
    end
    task automatic drive(input logic [2:0] f3, input logic [31:0] a, b, p, im);
        bus.funct3 = f3;
        bus.rd1    = a;
        bus.rd2    = b;
        bus.pc     = p;
        bus.imm    = im;
    endtask
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, b, p, im,
                         input logic tk, input logic er, input logic [31:0] tg);
        bit ok = 1'b0;
        sb.push_back(mk(tk, er, tg));
        @(posedge clk);
        #1;
        drive(f3, a, b, p, im);
        bus.br_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.br_ready;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept: got br_ready=0 for 20 cycles, required 1");
        end
        @(posedge clk);
        #1;
        bus.br_valid = 1'b0;
        drive(3'($urandom), $urandom, $urandom, $urandom, $urandom);
    endtask
    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.br_done;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no br_done in 40 cycles, required one");
        end
    endtask
    task automatic wait_pcsel();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.pc_sel;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL pcsel_timeout: got no pc_sel in 20 cycles, required one");
        end
    endtask
    task automatic chk_idle(input string name);
        chk({name, "_ready"}, 32'(bus.br_ready), 32'd1);
        chk({name, "_stall"}, 32'(bus.stall), 32'd0);
        chk({name, "_flush"}, 32'(bus.flush), 32'd0);
        chk({name, "_pc_sel"}, 32'(bus.pc_sel), 32'd0);
        chk({name, "_done"}, 32'(bus.br_done), 32'd0);
        chk({name, "_taken"}, 32'(bus.br_taken), 32'd0);
        chk({name, "_err"}, 32'(bus.br_err), 32'd0);
        chk({name, "_target"}, bus.pc_target, 32'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.br_valid = 1'b0;
        bus.kill     = 1'b0;
        drive(3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk_idle("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(3'b000, 32'hFFBBCCAA, 32'hFFBBCCAA, 32'h100, 32'h20, 1'b1, 1'b0, 32'h120);
        wait_done();
        issue(3'b000, 32'hFFBBCCAA, 32'hFFFFFFFF, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0);
        wait_done();
        issue(3'b100, 32'hF7A99BC4, 32'h00000001, 32'h200, 32'h40, 1'b1, 1'b0, 32'h240);
        wait_done();
        issue(3'b110, 32'hF7A99BC4, 32'h00000001, 32'h200, 32'h40, 1'b0, 1'b0, 32'h0);
        wait_done();
`ifdef BRANCH_STATS_EN
        @(posedge clk);
        #1;
        chk("cnt_branches", cnt_b, 32'd4);
        chk("cnt_taken", cnt_t, 32'd2);
`endif
        issue(3'b001, 32'h1, 32'h2, 32'hFFFFFFF0, 32'h20, 1'b1, 1'b0, 32'h10);
        wait_done();
        issue(3'b001, 32'h1, 32'h2, 32'hFFFFFFF0, 32'h2, 1'b0, 1'b1, 32'h0);
        wait_done();
        issue(3'b010, 32'h7, 32'h7, 32'h100, 32'h20, 1'b0, 1'b1, 32'h0);
        wait_done();
        issue(3'b011, 32'h1, 32'h1, 32'h100, 32'h20, 1'b0, 1'b1, 32'h0);
        wait_done();
        issue(3'b101, 32'h5, 32'hFFFFFFFD, 32'h0, 32'h8, 1'b1, 1'b0, 32'h8);
        wait_done();
        issue(3'b111, 32'h5, 32'hFFFFFFFD, 32'h0, 32'h8, 1'b0, 1'b0, 32'h0);
        wait_done();
        issue(3'b110, 32'h1, 32'hF7A99BC4, 32'h1000, 32'hC, 1'b1, 1'b0, 32'h100C);
        wait_done();
        issue(3'b001, 32'h9, 32'h9, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0);
        wait_done();
        issue(3'b000, 32'h0, 32'h0, 32'h100, 32'hFFFFFFF0, 1'b1, 1'b0, 32'hF0);
        wait_done();
        // kill in the first FLUSH cycle, replacement request held on br_valid
        issue(3'b000, 32'h3, 32'h3, 32'h400, 32'h10, 1'b1, 1'b0, 32'h410);
        wait_pcsel();
        @(posedge clk);
        #1;
        void'(sb.pop_front());
        sb.push_back(mk(1'b0, 1'b0, 32'h0));
        bus.kill = 1'b1;
        drive(3'b001, 32'h4, 32'h4, 32'h500, 32'h8);
        bus.br_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        @(negedge clk);
        chk("kill_ready", 32'(bus.br_ready), 32'd1);
        chk("kill_stall", 32'(bus.stall), 32'd0);
        chk("kill_flush", 32'(bus.flush), 32'd0);
        @(posedge clk);
        #1;
        bus.br_valid = 1'b0;
        wait_done();
        // kill beats br_valid while idle
        @(posedge clk);
        #1;
        drive(3'b000, 32'h1, 32'h1, 32'h0, 32'h4);
        bus.br_valid = 1'b1;
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.br_valid = 1'b0;
        bus.kill = 1'b0;
        @(negedge clk);
        chk("killprio_ready", 32'(bus.br_ready), 32'd1);
        chk("killprio_stall", 32'(bus.stall), 32'd0);
        // asynchronous reset while redirecting
        issue(3'b000, 32'h6, 32'h6, 32'h800, 32'h40, 1'b1, 1'b0, 32'h840);
        wait_pcsel();
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(3'b100, 32'h1, 32'h2, 32'h40, 32'h8, 1'b1, 1'b0, 32'h48);
        wait_done();
        repeat (3) @(negedge clk);
        chk("leftover", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
